// File: rtl/conv_mac_scheduler.sv
// Sequential FIR controller: loads TAPS coefficients, then for every accepted
// sample reuses one multiplier over TAPS cycles to build a full-precision output.
module conv_mac_scheduler #(
    parameter int DATA_W = 4,
    parameter int TAPS   = 2,
    parameter int ACC_W  = 2*DATA_W + $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_val,
    output logic              cfg_rdy,
    input  logic [DATA_W-1:0] cfg_msg,
    input  logic              req_val,
    output logic              req_rdy,
    input  logic [DATA_W-1:0] req_msg,
    output logic              resp_val,
    input  logic              resp_rdy,
    output logic [ACC_W-1:0]  resp_msg,
    output logic              busy
);
    localparam int IDX_W = $clog2(TAPS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(TAPS-1);

    typedef enum logic [1:0] {S_LOAD, S_WAIT, S_MAC, S_OUT} state_t;
    state_t state, state_nxt;

    logic [TAPS-1:0][DATA_W-1:0] h, x;
    logic [IDX_W-1:0]            tidx, midx;
    logic [ACC_W-1:0]            acc, prod;
    logic                        cfg_hs, req_hs, resp_hs;

    // cfg wins a WAIT collision because req_rdy is masked by cfg_val
    assign cfg_rdy  = (state == S_LOAD) || (state == S_WAIT);
    assign req_rdy  = (state == S_WAIT) && !cfg_val;
    assign resp_val = (state == S_OUT);
    assign resp_msg = acc;
    assign busy     = (state == S_MAC) || (state == S_OUT);

    assign cfg_hs  = cfg_val && cfg_rdy;
    assign req_hs  = req_val && req_rdy;
    assign resp_hs = resp_val && resp_rdy;

    assign prod = ACC_W'(x[midx]) * ACC_W'(h[midx]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: if (cfg_hs && tidx == LAST) state_nxt = S_WAIT;
            S_WAIT: begin
                if (cfg_hs)      state_nxt = S_LOAD;
                else if (req_hs) state_nxt = S_MAC;
            end
            S_MAC:  if (midx == LAST) state_nxt = S_OUT;
            S_OUT:  if (resp_hs) state_nxt = S_WAIT;
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h    <= '0;
            x    <= '0;
            tidx <= '0;
            midx <= '0;
            acc  <= '0;
        end else begin
            case (state)
                S_LOAD: if (cfg_hs) begin
                    h[tidx] <= cfg_msg;
                    tidx    <= (tidx == LAST) ? '0 : tidx + IDX_W'(1);
                end
                S_WAIT: begin
                    // reconfiguration restarts the filter with a zero-padded window
                    if (cfg_hs) begin
                        h[0] <= cfg_msg;
                        tidx <= IDX_W'(1);
                        x    <= '0;
                    end else if (req_hs) begin
                        x    <= {x[TAPS-2:0], req_msg};
                        acc  <= '0;
                        midx <= '0;
                    end
                end
                S_MAC: begin
                    acc  <= acc + prod;
                    midx <= midx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
